// File: rtl/contador_lectura_pkg.sv
// -----------------------------------------------------------------------------
// contador_pkg
// Shared definitions for the per-class word counter with snapshot read port.
//   DATA_W   : width of the incoming word
//   CNT_W    : width of each class counter and of the snapshot value
//   NCLASS   : number of traffic classes (selected by the top two data bits)
//   state_t  : read-handshake FSM states
//   clase_de : extracts the class field from an incoming word
// -----------------------------------------------------------------------------
package contador_pkg;

    localparam int DATA_W = 12;
    localparam int CNT_W  = 16;
    localparam int NCLASS = 4;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    // The class lives in the two most significant bits of the word.
    function automatic logic [1:0] clase_de(input logic [DATA_W-1:0] dato);
        return dato[DATA_W-1 -: 2];
    endfunction

endpackage

// File: rtl/contador_lectura_if.sv
// -----------------------------------------------------------------------------
// contador_lectura_if
// Snapshot read handshake between the counter block and its consumer.
//   req        : consumer asks for a snapshot (consumer -> counter)
//   idx        : class to read, sampled with req (consumer -> counter)
//   ack        : consumer has taken the snapshot (consumer -> counter)
//   valid_out  : snapshot is valid and held (counter -> consumer)
//   cuenta_out : snapshot of the selected class counter (counter -> consumer)
//   ovf_out    : snapshot of the selected sticky overflow flag (counter -> consumer)
// Modports: master = consumer side, slave = counter side.
// -----------------------------------------------------------------------------
interface contador_lectura_if #(
    parameter int CNT_W = contador_pkg::CNT_W
);
    import contador_pkg::*;

    logic             req;
    logic [1:0]       idx;
    logic             ack;
    logic             valid_out;
    logic [CNT_W-1:0] cuenta_out;
    logic             ovf_out;

    modport master (
        output req,
        output idx,
        output ack,
        input  valid_out,
        input  cuenta_out,
        input  ovf_out
    );

    modport slave (
        input  req,
        input  idx,
        input  ack,
        output valid_out,
        output cuenta_out,
        output ovf_out
    );

endinterface

// File: rtl/contador_lectura_clase.sv
// -----------------------------------------------------------------------------
// contador_clase
// One class counter: a CNT_W wrap-around counter with a sticky overflow flag.
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset, clears value and flag
//   inc    : count one word this cycle
//   clr    : clear value and flag this cycle (an increment at the same edge
//            leaves the counter at 1 with the flag clear)
//   value  : current count
//   ovf    : sticky flag, set when the counter wraps from all-ones to zero
// -----------------------------------------------------------------------------
module contador_clase #(
    parameter int CNT_W = contador_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] value,
    output logic             ovf
);
    import contador_pkg::*;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            // A word arriving on the clearing edge is the first of the new count.
            value <= inc ? CNT_W'(1) : '0;
            ovf   <= 1'b0;
        end else if (inc) begin
            value <= value + CNT_W'(1);
            if (value == '1) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/contador_lectura.sv
// -----------------------------------------------------------------------------
// contador_lectura
// Counts incoming words per traffic class in NCLASS independent counters and
// serves snapshot reads of any class through a req/valid/ack handshake.
// Counting never stalls; the read path applies no back-pressure.
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset (FSM, counters, flags, snapshot)
//   valid_in  : data_in carries a word this cycle
//   data_in   : incoming word, top two bits select the class
//   bus       : contador_lectura_if.slave (req, idx, ack, valid_out,
//               cuenta_out, ovf_out)
// Build option: CLEAR_ON_READ_EN -- capturing a class also clears its counter
// and overflow flag at the same edge. Undefined: reads are non-destructive.
// -----------------------------------------------------------------------------
module contador_lectura #(
    parameter int DATA_W = contador_pkg::DATA_W,
    parameter int CNT_W  = contador_pkg::CNT_W,
    parameter int NCLASS = contador_pkg::NCLASS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    contador_lectura_if.slave bus
);
    import contador_pkg::*;

    state_t            estado_q;
    state_t            estado_d;
    logic              captura;

    logic [1:0]        clase;
    logic [NCLASS-1:0] inc;
    logic [NCLASS-1:0] clr;
    logic [CNT_W-1:0]  valores [NCLASS];
    logic [NCLASS-1:0] ovfs;

    logic [CNT_W-1:0]  cuenta_q;
    logic              ovf_q;

    // ---------------------------------------------------------------- decode
    assign clase = clase_de(data_in);

    always_comb begin
        inc = '0;
        for (int unsigned k = 0; k < NCLASS; k++) begin
            inc[k] = valid_in && (clase == 2'(k));
        end
    end

`ifdef CLEAR_ON_READ_EN
    always_comb begin
        clr = '0;
        for (int unsigned k = 0; k < NCLASS; k++) begin
            clr[k] = captura && (bus.idx == 2'(k));
        end
    end
`else
    assign clr = '0;
`endif

    // -------------------------------------------------------------- counters
    for (genvar k = 0; k < NCLASS; k++) begin : g_clase
        contador_clase #(
            .CNT_W (CNT_W)
        ) u_clase (
            .clk   (clk),
            .reset (reset),
            .inc   (inc[k]),
            .clr   (clr[k]),
            .value (valores[k]),
            .ovf   (ovfs[k])
        );
    end

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q <= IDLE;
        end else begin
            estado_q <= estado_d;
        end
    end

    // req is only looked at in IDLE, so req+ack in WAIT_ACK simply returns.
    always_comb begin
        estado_d = estado_q;
        captura  = 1'b0;
        case (estado_q)
            IDLE: begin
                if (bus.req) begin
                    captura  = 1'b1;
                    estado_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (bus.ack) begin
                    estado_d = IDLE;
                end
            end
            default: estado_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------- snapshot
    // Sampled from the counter registers, so a same-edge increment is not seen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cuenta_q <= '0;
            ovf_q    <= 1'b0;
        end else if (captura) begin
            cuenta_q <= valores[bus.idx];
            ovf_q    <= ovfs[bus.idx];
        end
    end

    assign bus.valid_out  = (estado_q == WAIT_ACK);
    assign bus.cuenta_out = cuenta_q;
    assign bus.ovf_out    = ovf_q;

endmodule

// File: tb/tb_contador_lectura.sv
// -----------------------------------------------------------------------------
// tb_contador_lectura
// Self-checking bench for contador_lectura: directed scenarios plus random
// traffic, compared every cycle against a behavioural model of the counts,
// overflow flags and the pending snapshot.
// Honours CLEAR_ON_READ_EN when the design is built with it.
// -----------------------------------------------------------------------------
module tb_contador_lectura;
    import contador_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic [11:0] data_in;

    contador_lectura_if bus ();

    contador_lectura dut (
        .clk      (clk),
        .reset    (rst_n),
        .valid_in (valid_in),
        .data_in  (data_in),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int unsigned m_cnt [4];
    bit          m_ovf [4];
    bit          m_wait;
    int unsigned s_cnt;
    bit          s_ovf;

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelo_reset();
        for (int k = 0; k < 4; k++) begin
            m_cnt[k] = 0;
            m_ovf[k] = 0;
        end
        m_wait = 0;
        s_cnt  = 0;
        s_ovf  = 0;
    endtask

    // Effect of one clock edge, using the values as they stood before it.
    task automatic modelo_flanco(input logic v, input logic [11:0] d,
                                 input logic r, input logic [1:0] i, input logic a);
        int clr_k;
        int c;
        clr_k = -1;
        c = int'(d[11:10]);
        if (!m_wait) begin
            if (r) begin
                s_cnt  = m_cnt[i];
                s_ovf  = m_ovf[i];
                m_wait = 1;
`ifdef CLEAR_ON_READ_EN
                clr_k = int'(i);
`endif
            end
        end else if (a) begin
            m_wait = 0;
        end
        if (clr_k >= 0) begin
            m_cnt[clr_k] = 0;
            m_ovf[clr_k] = 0;
        end
        if (v) begin
            if (c == clr_k) begin
                m_cnt[c] = 1;
            end else begin
                if (m_cnt[c] == 65535) m_ovf[c] = 1;
                m_cnt[c] = (m_cnt[c] + 1) % 65536;
            end
        end
    endtask

    // Drive one cycle of inputs, advance one edge, check outputs #1 later.
    task automatic paso(input logic v, input logic [11:0] d,
                        input logic r, input logic [1:0] i, input logic a);
        valid_in = v;
        data_in  = d;
        bus.req  = r;
        bus.idx  = i;
        bus.ack  = a;
        @(posedge clk);
        modelo_flanco(v, d, r, i, a);
        #1;
        comprobar("valid_out", 32'(bus.valid_out), 32'(m_wait));
        if (m_wait) begin
            comprobar("cuenta_out", 32'(bus.cuenta_out), s_cnt);
            comprobar("ovf_out", 32'(bus.ovf_out), 32'(s_ovf));
        end
    endtask

    // Asynchronous reset asserted between edges; outputs must drop at once.
    task automatic reinicio();
        #2;
        rst_n = 1'b0;
        #1;
        comprobar("rst_valid", 32'(bus.valid_out), 32'd0);
        comprobar("rst_cuenta", 32'(bus.cuenta_out), 32'd0);
        comprobar("rst_ovf", 32'(bus.ovf_out), 32'd0);
        modelo_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [15:0] retenido;

    initial begin
        rst_n    = 1'b0;
        valid_in = 1'b0;
        data_in  = '0;
        bus.req  = 1'b0;
        bus.idx  = '0;
        bus.ack  = 1'b0;
        modelo_reset();

        repeat (3) @(posedge clk);
        #1;
        comprobar("init_valid", 32'(bus.valid_out), 32'd0);
        comprobar("init_cuenta", 32'(bus.cuenta_out), 32'd0);
        comprobar("init_ovf", 32'(bus.ovf_out), 32'd0);
        rst_n = 1'b1;

        // Count/read: 5 words to class 2, 3 to class 0
        for (int n = 0; n < 5; n++) paso(1'b1, 12'h800 + 12'(n), 1'b0, 2'd0, 1'b0);
        for (int n = 0; n < 3; n++) paso(1'b1, 12'($urandom_range(0, 1023)), 1'b0, 2'd0, 1'b0);
        paso(1'b0, 12'h000, 1'b1, 2'd2, 1'b0);
        comprobar("leer_c2_valid", 32'(bus.valid_out), 32'd1);
        comprobar("leer_c2", 32'(bus.cuenta_out), 32'd5);
        comprobar("leer_c2_ovf", 32'(bus.ovf_out), 32'd0);
        paso(1'b0, 12'h000, 1'b0, 2'd0, 1'b1);
        comprobar("ack_baja", 32'(bus.valid_out), 32'd0);
        paso(1'b0, 12'h000, 1'b1, 2'd0, 1'b0);
        comprobar("leer_c0", 32'(bus.cuenta_out), 32'd3);
        paso(1'b0, 12'h000, 1'b0, 2'd0, 1'b1);

        // Same-cycle collision on class 1 at count 7
        for (int n = 0; n < 7; n++) paso(1'b1, 12'h400 + 12'(n), 1'b0, 2'd0, 1'b0);
        paso(1'b1, 12'h455, 1'b1, 2'd1, 1'b0);
        comprobar("colision", 32'(bus.cuenta_out), 32'd7);
        paso(1'b0, 12'h000, 1'b0, 2'd0, 1'b1);
        paso(1'b0, 12'h000, 1'b1, 2'd1, 1'b0);
`ifdef CLEAR_ON_READ_EN
        comprobar("post_colision", 32'(bus.cuenta_out), 32'd1);
`else
        comprobar("post_colision", 32'(bus.cuenta_out), 32'd8);
`endif
        paso(1'b0, 12'h000, 1'b0, 2'd0, 1'b1);

        // Handshake hold: ack low for 10 cycles while class-2 words arrive
        paso(1'b1, 12'h8AA, 1'b1, 2'd2, 1'b0);
        retenido = bus.cuenta_out;
        for (int n = 0; n < 10; n++) begin
            paso(1'b1, 12'h800 | 12'($urandom_range(0, 1023)), 1'b1,
                 2'($urandom_range(0, 3)), 1'b0);
            comprobar("retencion", 32'(bus.cuenta_out), 32'(retenido));
        end
        paso(1'b0, 12'h000, 1'b0, 2'd0, 1'b1);
        comprobar("ack_libera", 32'(bus.valid_out), 32'd0);

        // Back-to-back: req N, ack N+1, req N+2
        paso(1'b0, 12'h000, 1'b1, 2'd2, 1'b0);
        comprobar("b2b_1", 32'(bus.valid_out), 32'd1);
        paso(1'b0, 12'h000, 1'b0, 2'd0, 1'b1);
        comprobar("b2b_hueco", 32'(bus.valid_out), 32'd0);
        paso(1'b0, 12'h000, 1'b1, 2'd0, 1'b0);
        comprobar("b2b_2", 32'(bus.valid_out), 32'd1);

        // Reset while waiting for ack, then every class reads 0
        reinicio();
        for (int k = 0; k < 4; k++) begin
            paso(1'b0, 12'h000, 1'b1, 2'(k), 1'b0);
            comprobar("post_rst_cuenta", 32'(bus.cuenta_out), 32'd0);
            paso(1'b0, 12'h000, 1'b0, 2'd0, 1'b1);
        end

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            paso(1'($urandom_range(0, 1)), 12'($urandom),
                 ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 2) == 0));
        end
        paso(1'b0, 12'h000, 1'b0, 2'd0, 1'b1);

        // Wrap: 65536 class-3 words from a clean state
        reinicio();
        for (int n = 0; n < 65536; n++) begin
            paso(1'b1, 12'hC00 | 12'($urandom_range(0, 1023)), 1'b0, 2'd0, 1'b0);
        end
        paso(1'b0, 12'h000, 1'b1, 2'd3, 1'b0);
        comprobar("wrap_cuenta", 32'(bus.cuenta_out), 32'd0);
        comprobar("wrap_ovf", 32'(bus.ovf_out), 32'd1);
        paso(1'b0, 12'h000, 1'b0, 2'd0, 1'b1);
        paso(1'b0, 12'h000, 1'b1, 2'd3, 1'b0);
`ifdef CLEAR_ON_READ_EN
        comprobar("wrap2_ovf", 32'(bus.ovf_out), 32'd0);
`else
        comprobar("wrap2_ovf", 32'(bus.ovf_out), 32'd1);
`endif
        comprobar("wrap2_cuenta", 32'(bus.cuenta_out), 32'd0);
        paso(1'b0, 12'h000, 1'b0, 2'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
